sample_loader: RTL and testbench

//  Front stage of the FFT pipeline. Accepts real input samples over a valid/ready stream.

---
 rtl/sample_loader.sv | 161 ++++++++++++++++
 tb/tb_sample_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sample_loader.sv
// Front stage of the FFT pipeline: packs real samples into complex words and writes a frame pairwise.
// Optional drop counter output o_drop_cnt is enabled by defining SAMPLE_LOADER_STATS_EN.
module sample_loader #(
    parameter int unsigned WORD_SIZE    = 74,
    parameter int unsigned ADDR_SIZE    = 5,
    parameter int unsigned FFT_SIZE     = 4,
    parameter int unsigned SAMPLE_WIDTH = 16
) (
    input  logic                    i_CLK,
    input  logic                    i_RST,
    input  logic                    i_start,
    input  logic                    i_valid,
    input  logic [SAMPLE_WIDTH-1:0] i_sample,
    output logic                    o_ready,
    output logic                    o_busy,
    output logic                    o_wren,
    output logic [ADDR_SIZE-1:0]    o_wraddr_A,
    output logic [ADDR_SIZE-1:0]    o_wraddr_B,
    output logic [WORD_SIZE-1:0]    o_wrdata_A,
    output logic [WORD_SIZE-1:0]    o_wrdata_B,
    output logic                    o_done
`ifdef SAMPLE_LOADER_STATS_EN
    ,
    output logic [15:0]             o_drop_cnt
`endif
);

    localparam int unsigned HALF  = WORD_SIZE / 2;
    localparam int unsigned PAIRS = FFT_SIZE / 2;
    localparam int unsigned K_W   = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(PAIRS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FILL_A = 3'd1;
    localparam logic [2:0] S_FILL_B = 3'd2;
    localparam logic [2:0] S_FLUSH  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]           state, state_nxt;
    logic [K_W-1:0]       k, k_nxt;
    logic [WORD_SIZE-1:0] held, held_nxt;
    logic                 ready_nxt, busy_nxt, wren_nxt, done_nxt;
    logic [ADDR_SIZE-1:0] addr_a_nxt, addr_b_nxt;
    logic [WORD_SIZE-1:0] data_a_nxt, data_b_nxt;
    logic                 accept_c;
    logic                 start_ok_c;
    logic [WORD_SIZE-1:0] word_c;

    // Real part is the sign-extended sample, imaginary part is zero.
    assign word_c     = WORD_SIZE'({HALF'($signed(i_sample)), HALF'(0)});
    assign accept_c   = i_valid && o_ready;
    assign start_ok_c = i_start && ((state == S_IDLE) || (state == S_DONE));

    always_comb begin
        state_nxt  = state;
        k_nxt      = k;
        held_nxt   = held;
        wren_nxt   = 1'b0;
        done_nxt   = o_done;
        addr_a_nxt = o_wraddr_A;
        addr_b_nxt = o_wraddr_B;
        data_a_nxt = o_wrdata_A;
        data_b_nxt = o_wrdata_B;
        ready_nxt  = 1'b0;
        busy_nxt   = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    state_nxt = S_FILL_A;
                    done_nxt  = 1'b0;
                    k_nxt     = '0;
                end
            end
            S_FILL_A: begin
                if (accept_c) begin
                    held_nxt  = word_c;
                    state_nxt = S_FILL_B;
                end
            end
            S_FILL_B: begin
                if (accept_c) begin
                    wren_nxt   = 1'b1;
                    addr_a_nxt = ADDR_SIZE'({k, 1'b0});
                    addr_b_nxt = ADDR_SIZE'({k, 1'b1});
                    data_a_nxt = held;
                    data_b_nxt = word_c;
                    if (k == K_LAST) begin
                        state_nxt = S_FLUSH;
                    end else begin
                        k_nxt     = k + K_W'(1);
                        state_nxt = S_FILL_A;
                    end
                end
            end
            S_FLUSH: begin
                done_nxt  = 1'b1;
                state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // Handshake and status outputs are registered copies of the next state.
        ready_nxt = (state_nxt == S_FILL_A) || (state_nxt == S_FILL_B);
        busy_nxt  = ready_nxt || (state_nxt == S_FLUSH);
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state      <= S_IDLE;
            k          <= '0;
            held       <= '0;
            o_ready    <= 1'b0;
            o_busy     <= 1'b0;
            o_wren     <= 1'b0;
            o_done     <= 1'b0;
            o_wraddr_A <= '0;
            o_wraddr_B <= '0;
            o_wrdata_A <= '0;
            o_wrdata_B <= '0;
        end else begin
            state      <= state_nxt;
            k          <= k_nxt;
            held       <= held_nxt;
            o_ready    <= ready_nxt;
            o_busy     <= busy_nxt;
            o_wren     <= wren_nxt;
            o_done     <= done_nxt;
            o_wraddr_A <= addr_a_nxt;
            o_wraddr_B <= addr_b_nxt;
            o_wrdata_A <= data_a_nxt;
            o_wrdata_B <= data_b_nxt;
        end
    end

`ifdef SAMPLE_LOADER_STATS_EN
    logic [15:0] drop_nxt;

    // Saturating count of offered-but-refused cycles; an honoured start clears it.
    always_comb begin
        drop_nxt = o_drop_cnt;
        if (start_ok_c) begin
            drop_nxt = '0;
        end else if (i_valid && !o_ready && (o_drop_cnt != 16'hFFFF)) begin
            drop_nxt = o_drop_cnt + 16'd1;
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            o_drop_cnt <= '0;
        end else begin
            o_drop_cnt <= drop_nxt;
        end
    end
`else
    logic unused_c;
    assign unused_c = start_ok_c;
`endif

endmodule

// File: tb/tb_sample_loader.sv
// Self-checking bench for sample_loader: directed vector table, corner sequences and a randomized model run.
module tb_sample_loader;

    localparam int unsigned WS = 74;
    localparam int unsigned AS = 5;
    localparam int unsigned FS = 4;
    localparam int unsigned SW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          valid = 1'b0;
    logic [SW-1:0] sample = '0;
    logic          ready, busy, wren, done;
    logic [AS-1:0] addr_a, addr_b;
    logic [WS-1:0] data_a, data_b;
`ifdef SAMPLE_LOADER_STATS_EN
    logic [15:0]   drop_cnt;
`endif

    int passed = 0;
    int total  = 0;

    sample_loader #(.WORD_SIZE(WS), .ADDR_SIZE(AS), .FFT_SIZE(FS), .SAMPLE_WIDTH(SW)) dut (
        .i_CLK      (clk),
        .i_RST      (rst),
        .i_start    (start),
        .i_valid    (valid),
        .i_sample   (sample),
        .o_ready    (ready),
        .o_busy     (busy),
        .o_wren     (wren),
        .o_wraddr_A (addr_a),
        .o_wraddr_B (addr_b),
        .o_wrdata_A (data_a),
        .o_wrdata_B (data_b),
        .o_done     (done)
`ifdef SAMPLE_LOADER_STATS_EN
        ,
        .o_drop_cnt (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else passed++;
    endtask

    function automatic logic [WS-1:0] pack(input logic [SW-1:0] s);
        logic signed [WS/2-1:0] re;
        re = $signed(s);
        return {re, {(WS/2){1'b0}}};
    endfunction

    // Behavioural model: tracks frame progress as a count of accepted samples.
    logic          m_ready, m_busy, m_wren, m_done, m_active, m_flush;
    logic [AS-1:0] m_addr_a, m_addr_b;
    logic [WS-1:0] m_data_a, m_data_b;
    int            m_nacc;
    int            m_drop;
    logic [SW-1:0] mbuf [FS];

    task automatic model_reset();
        m_ready = 0; m_busy = 0; m_wren = 0; m_done = 0; m_active = 0; m_flush = 0;
        m_addr_a = '0; m_addr_b = '0; m_data_a = '0; m_data_b = '0;
        m_nacc = 0; m_drop = 0;
    endtask

    task automatic model_step();
        logic acc, hs;
        acc = valid && m_ready;
        hs  = start && !m_busy;
        m_wren = 0;
        if (hs) m_drop = 0;
        else if (valid && !m_ready && m_drop != 65535) m_drop++;
        if (hs) begin
            m_active = 1; m_nacc = 0; m_flush = 0; m_done = 0;
        end else if (acc) begin
            mbuf[m_nacc] = sample;
            m_nacc++;
            if (m_nacc % 2 == 0) begin
                m_wren   = 1;
                m_addr_a = AS'(m_nacc - 2);
                m_addr_b = AS'(m_nacc - 1);
                m_data_a = pack(mbuf[m_nacc-2]);
                m_data_b = pack(sample);
            end
            if (m_nacc == FS) m_flush = 1;
        end else if (m_flush) begin
            m_flush = 0; m_active = 0; m_done = 1;
        end
        m_ready = m_active && !m_flush && (m_nacc < FS);
        m_busy  = m_active;
    endtask

    task automatic run_cycle(input logic st, input logic v, input logic [SW-1:0] s);
        start = st; valid = v; sample = s;
        model_step();
        @(posedge clk); #1;
        chk("ready", ready, m_ready);
        chk("busy", busy, m_busy);
        chk("wren", wren, m_wren);
        chk("done", done, m_done);
        chk("addr_a", addr_a, m_addr_a);
        chk("addr_b", addr_b, m_addr_b);
        chk("data_a", data_a, m_data_a);
        chk("data_b", data_b, m_data_b);
`ifdef SAMPLE_LOADER_STATS_EN
        chk("drop_cnt", drop_cnt, 16'(m_drop));
`endif
    endtask

    typedef struct {
        logic          st, v;
        logic [SW-1:0] s;
        logic          rdy, bsy, wr, dn;
        logic [AS-1:0] aa, ab;
        logic [SW-1:0] sa, sb;
    } vec_t;

    vec_t vt[14];

    initial begin
        vt[0]  = '{1, 0, 16'd0,    1, 1, 0, 0, 5'd0, 5'd0, 16'd0, 16'd0};
        vt[1]  = '{0, 1, 16'd1,    1, 1, 0, 0, 5'd0, 5'd0, 16'd0, 16'd0};
        vt[2]  = '{0, 1, 16'd2,    1, 1, 1, 0, 5'd0, 5'd1, 16'd1, 16'd2};
        vt[3]  = '{0, 1, 16'd3,    1, 1, 0, 0, 5'd0, 5'd1, 16'd1, 16'd2};
        vt[4]  = '{0, 1, 16'd4,    0, 1, 1, 0, 5'd2, 5'd3, 16'd3, 16'd4};
        vt[5]  = '{0, 0, 16'd0,    0, 0, 0, 1, 5'd2, 5'd3, 16'd3, 16'd4};
        vt[6]  = '{0, 1, 16'd5,    0, 0, 0, 1, 5'd2, 5'd3, 16'd3, 16'd4};
        vt[7]  = '{1, 1, 16'd6,    1, 1, 0, 0, 5'd2, 5'd3, 16'd3, 16'd4};
        vt[8]  = '{0, 1, 16'd7,    1, 1, 0, 0, 5'd2, 5'd3, 16'd3, 16'd4};
        vt[9]  = '{0, 0, 16'd0,    1, 1, 0, 0, 5'd2, 5'd3, 16'd3, 16'd4};
        vt[10] = '{0, 1, 16'd8,    1, 1, 1, 0, 5'd0, 5'd1, 16'd7, 16'd8};
        vt[11] = '{1, 1, 16'd9,    1, 1, 0, 0, 5'd0, 5'd1, 16'd7, 16'd8};
        vt[12] = '{0, 1, 16'hFFFD, 0, 1, 1, 0, 5'd2, 5'd3, 16'd9, 16'hFFFD};
        vt[13] = '{0, 0, 16'd0,    0, 0, 0, 1, 5'd2, 5'd3, 16'd9, 16'hFFFD};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wren", wren, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_addr", {addr_a, addr_b}, '0);
        chk("rst_data", {data_a, data_b}, '0);
        rst = 1'b0;

        // Directed table: basic frame, start in DONE, start while busy, negative sample
        for (int i = 0; i < 14; i++) begin
            start = vt[i].st; valid = vt[i].v; sample = vt[i].s;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_ready", i), ready, vt[i].rdy);
            chk($sformatf("vec%0d_busy", i), busy, vt[i].bsy);
            chk($sformatf("vec%0d_wren", i), wren, vt[i].wr);
            chk($sformatf("vec%0d_done", i), done, vt[i].dn);
            chk($sformatf("vec%0d_addr_a", i), addr_a, vt[i].aa);
            chk($sformatf("vec%0d_addr_b", i), addr_b, vt[i].ab);
            chk($sformatf("vec%0d_data_a", i), data_a, pack(vt[i].sa));
            chk($sformatf("vec%0d_data_b", i), data_b, pack(vt[i].sb));
        end

        // Most negative sample sign-extends into the real half
        start = 1; valid = 0; @(posedge clk); #1;
        start = 0; valid = 1; sample = 16'h8000; @(posedge clk); #1;
        sample = 16'h0001; @(posedge clk); #1;
        chk("neg_wren", wren, 1'b1);
        chk("neg_real", data_a[WS-1:WS/2], 37'h1FFFFF8000);
        chk("neg_imag", data_a[WS/2-1:0], 37'h0);

        // Third sample accepted, then asynchronous reset mid-frame
        sample = 16'h0002; @(posedge clk); #1;
        chk("pre_rst_ready", ready, 1'b1);
        #2; rst = 1; #1;
        chk("async_rst_ready", ready, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_out", {wren, done, addr_a, addr_b, data_a, data_b}, '0);
        sample = 16'h0003;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("in_rst_wren", wren, 1'b0);
        end
        rst = 0; valid = 0;
        model_reset();
        run_cycle(0, 1, 16'd3);

        // Fresh frame after reset writes from address 0
        run_cycle(1, 0, 16'd0);
        for (int i = 0; i < FS; i++) run_cycle(0, 1, 16'(100 + i));
        run_cycle(0, 0, 16'd0);

        // Valid every 3rd cycle
        run_cycle(1, 0, 16'd0);
        for (int i = 0; i < 15; i++) run_cycle(0, (i % 3) == 2, 16'(200 + i));
        run_cycle(0, 1, 16'd0);

        // Start pulsed mid-frame, then start in DONE
        run_cycle(1, 0, 16'd0);
        run_cycle(0, 1, 16'd11);
        run_cycle(1, 1, 16'd12);
        run_cycle(1, 0, 16'd0);
        run_cycle(0, 1, 16'd13);
        run_cycle(0, 1, 16'd14);
        run_cycle(0, 0, 16'd0);
        run_cycle(1, 1, 16'd15);
        run_cycle(0, 1, 16'd16);
        run_cycle(0, 1, 16'd17);

        // Randomized run against the model
        for (int i = 0; i < 2000; i++)
            run_cycle($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, 16'($urandom));

`ifdef SAMPLE_LOADER_STATS_EN
        // Refused cycles in IDLE, then an honoured start clears the count
        rst = 1; #1; rst = 0; valid = 0; start = 0;
        model_reset();
        for (int i = 0; i < 5; i++) run_cycle(0, 1, 16'd1);
        chk("drop_five", drop_cnt, 16'd5);
        run_cycle(1, 0, 16'd0);
        chk("drop_cleared", drop_cnt, 16'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
